md_alu_seq: RTL

- Iterative multiply/divide sequencer in the execute stage.
- Borrows the shared 32-bit ALU for WIDTH cycles to run shift-add multiply or restoring divide.
- While idle, passes the pipeline's ALU request straight through, so it also arbitrates ALU ownership.
- Raises busy so the hazard unit stalls the pipeline until done.

---
 rtl/md_alu_seq.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/md_alu_seq.sv
// -----------------------------------------------------------------------------
// md_alu_seq
//
// Iterative multiply/divide sequencer for the execute stage. While an
// operation is in flight it borrows the shared WIDTH-bit add/sub ALU for
// WIDTH cycles and runs either a shift-add multiply or a restoring divide.
// When no operation is running, it passes the pipeline's own ALU request
// straight through, so it also acts as the ALU ownership mux.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   start              begin a new operation (honoured only when idle)
//   flush              abort any operation; beats start in the same cycle
//   op[1:0]            00 MUL low, 01 MULHU high, 10 DIVU quotient, 11 REMU
//   src_a, src_b       multiplicand/dividend, multiplier/divisor (unsigned)
//   pipe_alu_*         ALU request from the pipeline (ctrl: 0 add, 1 sub)
//   alu_ctrl/data_1/2  drive to the shared ALU
//   alu_out            combinational result from the shared ALU
//   busy               operation in flight, stalls the pipeline
//   done               one-cycle pulse, result valid
//   result             selected result, held until the next done
// -----------------------------------------------------------------------------
module md_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             pipe_alu_ctrl,
  input  logic [WIDTH-1:0] pipe_alu_data_1,
  input  logic [WIDTH-1:0] pipe_alu_data_2,
  output logic             alu_ctrl,
  output logic [WIDTH-1:0] alu_data_1,
  output logic [WIDTH-1:0] alu_data_2,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;

  // The two algorithms share one register set:
  //   acc  : hi (multiply)   / rem (divide)
  //   sr   : lo (multiply)   / quo (divide)   -- the shifting register
  //   opnd : mc (multiply)   / d   (divide)   -- constant for the operation
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;

  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_div;
  logic [WIDTH:0]     sh;
  logic               div_ge;
  logic               mul_carry;
  logic               qbit;
  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   step_sr;

  assign is_div = op_q[1];

  // Divide: partial remainder shifted left with the next dividend bit.
  // The compare is done here at WIDTH+1 bits rather than through the ALU,
  // because the shifted value can exceed WIDTH bits.
  assign sh     = {acc_q, sr_q[WIDTH-1]};
  assign div_ge = (sh >= {1'b0, opnd_q});

  // ---------------------------------------------------------------------------
  // Shared ALU ownership. In RUN the sequencer drives operands on every step,
  // including multiply steps with lo[0]=0 where alu_out is then ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (state_q == S_RUN) begin
      alu_ctrl   = is_div;                         // multiply adds, divide subtracts
      alu_data_1 = is_div ? sh[WIDTH-1:0] : acc_q;
      alu_data_2 = opnd_q;
    end else begin
      alu_ctrl   = pipe_alu_ctrl;
      alu_data_1 = pipe_alu_data_1;
      alu_data_2 = pipe_alu_data_2;
    end
  end

  // ---------------------------------------------------------------------------
  // One algorithm step, computed from the current registers and alu_out.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    mul_carry = 1'b0;
    qbit      = 1'b0;
    step_acc  = acc_q;
    step_sr   = sr_q;
    if (is_div) begin
      if (div_ge) begin
        qbit     = 1'b1;
        step_acc = alu_out;                        // sh - d, always fits in WIDTH
      end else begin
        step_acc = sh[WIDTH-1:0];
      end
      step_sr = {sr_q[WIDTH-2:0], qbit};
    end else begin
      // Unsigned wrap of hi + mc shows up as a sum smaller than hi.
      mul_carry = (alu_out < acc_q);
      if (sr_q[0]) begin
        {step_acc, step_sr} = {mul_carry, alu_out, sr_q[WIDTH-1:1]};
      end else begin
        {step_acc, step_sr} = {1'b0, acc_q, sr_q[WIDTH-1:1]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    sr_d     = sr_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          acc_d   = '0;
          // Multiply: lo = multiplier, mc = multiplicand.
          // Divide:   quo = dividend,  d  = divisor.
          sr_d    = op[1] ? src_a : src_b;
          opnd_d  = op[1] ? src_b : src_a;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d  = step_acc;
          sr_d   = step_sr;
          busy_d = 1'b1;
          if (cnt_q == '0) begin
            // The last step's outcome is selected here so result is already
            // valid in the cycle done is high. MUL/DIVU take the shifting
            // register, MULHU/REMU take the accumulator.
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = op_q[0] ? step_acc : step_sr;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        // done and result were set on entry; flush here changes nothing more.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      sr_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      sr_q     <= sr_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
